// File: rtl/fifo_pkg.sv
// Shared FIFO types: the registered status bundle and the pointer-width helper.
// Intended to be reused by single- and dual-clock FIFO controllers.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic ovf;
        logic udf;
    } fifo_status_t;

    // One extra wrap bit above the RAM address distinguishes full from empty.
    function automatic int pntr_width(input int awidth);
        return awidth + 1;
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller: write/read pointers, occupancy count and
// registered status flags that gate the dual-port FIFO RAM.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int AWIDTH             = 3,
    parameter int ALMOST_FULL_VALUE  = 6,
    parameter int ALMOST_EMPTY_VALUE = 2
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wr_req_i,
    input  logic              rd_req_i,
    output logic [AWIDTH-1:0] wr_pntr_o,
    output logic [AWIDTH-1:0] rd_pntr_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam int PW    = pntr_width(AWIDTH);
    localparam int DEPTH = 2 ** AWIDTH;

    localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
    localparam logic [PW-1:0] AF_W    = PW'(ALMOST_FULL_VALUE);
    localparam logic [PW-1:0] AE_W    = PW'(ALMOST_EMPTY_VALUE);

    localparam fifo_status_t STATUS_RST = '{
        full:         1'b0,
        empty:        1'b1,
        almost_full:  1'b0,
        almost_empty: 1'b1,
        ovf:          1'b0,
        udf:          1'b0
    };

    if (AWIDTH < 1) begin : g_bad_awidth
        $error("fifo_ctrl: AWIDTH must be at least 1");
    end
    if (ALMOST_FULL_VALUE < 1 || ALMOST_FULL_VALUE > DEPTH) begin : g_bad_af
        $error("fifo_ctrl: ALMOST_FULL_VALUE outside 1..2**AWIDTH");
    end
    if (ALMOST_EMPTY_VALUE < 1 || ALMOST_EMPTY_VALUE > DEPTH) begin : g_bad_ae
        $error("fifo_ctrl: ALMOST_EMPTY_VALUE outside 1..2**AWIDTH");
    end

    logic [PW-1:0] wr_pntr_reg, wr_pntr_next;
    logic [PW-1:0] rd_pntr_reg, rd_pntr_next;
    logic [PW-1:0] usedw_reg, usedw_next;
    fifo_status_t  status_reg, status_next;

    logic wr_acc;
    logic rd_acc;

    // Acceptance uses the registered flags, matching the RAM's own gating.
    assign wr_acc = wr_req_i & ~status_reg.full;
    assign rd_acc = rd_req_i & ~status_reg.empty;

    always_comb begin
        wr_pntr_next = wr_pntr_reg + PW'(wr_acc);
        rd_pntr_next = rd_pntr_reg + PW'(rd_acc);
        usedw_next   = usedw_reg + PW'(wr_acc) - PW'(rd_acc);

        status_next              = status_reg;
        status_next.full         = (usedw_next == DEPTH_W);
        status_next.empty        = (usedw_next == '0);
        status_next.almost_full  = (usedw_next >= AF_W);
        status_next.almost_empty = (usedw_next < AE_W);
        status_next.ovf          = status_reg.ovf | (wr_req_i & status_reg.full);
        status_next.udf          = status_reg.udf | (rd_req_i & status_reg.empty);
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            wr_pntr_reg <= '0;
            rd_pntr_reg <= '0;
            usedw_reg   <= '0;
            status_reg  <= STATUS_RST;
        end else begin
            wr_pntr_reg <= wr_pntr_next;
            rd_pntr_reg <= rd_pntr_next;
            usedw_reg   <= usedw_next;
            status_reg  <= status_next;
        end
    end

    // RAM addresses are the pointers without the wrap bit.
    for (genvar gi = 0; gi < AWIDTH; gi++) begin : g_pntr_out
        assign wr_pntr_o[gi] = wr_pntr_reg[gi];
        assign rd_pntr_o[gi] = rd_pntr_reg[gi];
    end

    assign usedw_o        = usedw_reg;
    assign full_o         = status_reg.full;
    assign empty_o        = status_reg.empty;
    assign almost_full_o  = status_reg.almost_full;
    assign almost_empty_o = status_reg.almost_empty;
    assign ovf_o          = status_reg.ovf;
    assign udf_o          = status_reg.udf;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl: a behavioural occupancy model queues the
// expected outputs per cycle, which are compared after the clock edge.
module tb_fifo_ctrl;

    localparam int AWIDTH = 3;
    localparam int DEPTH  = 2 ** AWIDTH;
    localparam int AFV    = 6;
    localparam int AEV    = 2;

    logic              clk = 1'b0;
    logic              srst = 1'b0;
    logic              wr_req = 1'b0;
    logic              rd_req = 1'b0;
    logic [AWIDTH-1:0] wr_pntr;
    logic [AWIDTH-1:0] rd_pntr;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AWIDTH:0]   usedw;
    logic              ovf;
    logic              udf;

    fifo_ctrl #(
        .AWIDTH            (AWIDTH),
        .ALMOST_FULL_VALUE (AFV),
        .ALMOST_EMPTY_VALUE(AEV)
    ) dut (
        .clk_i         (clk),
        .srst_i        (srst),
        .wr_req_i      (wr_req),
        .rd_req_i      (rd_req),
        .wr_pntr_o     (wr_pntr),
        .rd_pntr_o     (rd_pntr),
        .full_o        (full),
        .empty_o       (empty),
        .almost_full_o (almost_full),
        .almost_empty_o(almost_empty),
        .usedw_o       (usedw),
        .ovf_o         (ovf),
        .udf_o         (udf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wp;
        int rp;
        int cnt;
        int full;
        int empty;
        int af;
        int ae;
        int ovf;
        int udf;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model state: pointers counted modulo 2*DEPTH, occupancy as a plain int.
    int m_wp  = 0;
    int m_rp  = 0;
    int m_cnt = 0;
    int m_ovf = 0;
    int m_udf = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL cyc=%0d %s: got %0d expected %0d", cyc, tag, obs, expv);
    endtask

    task automatic step(input logic w, input logic r, input logic rst_n);
        exp_t e;
        int   wacc;
        int   racc;
        @(negedge clk);
        wr_req = w;
        rd_req = r;
        srst   = rst_n;
        if (!rst_n) begin
            m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
        end else begin
            wacc = (w && m_cnt != DEPTH) ? 1 : 0;
            racc = (r && m_cnt != 0) ? 1 : 0;
            if (w && m_cnt == DEPTH) m_ovf = 1;
            if (r && m_cnt == 0) m_udf = 1;
            m_wp  = (m_wp + wacc) % (2 * DEPTH);
            m_rp  = (m_rp + racc) % (2 * DEPTH);
            m_cnt = m_cnt + wacc - racc;
        end
        e.wp    = m_wp % DEPTH;
        e.rp    = m_rp % DEPTH;
        e.cnt   = m_cnt;
        e.full  = (m_cnt == DEPTH) ? 1 : 0;
        e.empty = (m_cnt == 0) ? 1 : 0;
        e.af    = (m_cnt >= AFV) ? 1 : 0;
        e.ae    = (m_cnt < AEV) ? 1 : 0;
        e.ovf   = m_ovf;
        e.udf   = m_udf;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("wr_pntr", 32'(wr_pntr), e.wp);
            check_eq("rd_pntr", 32'(rd_pntr), e.rp);
            check_eq("usedw", 32'(usedw), e.cnt);
            check_eq("full", 32'(full), e.full);
            check_eq("empty", 32'(empty), e.empty);
            check_eq("almost_full", 32'(almost_full), e.af);
            check_eq("almost_empty", 32'(almost_empty), e.ae);
            check_eq("ovf", 32'(ovf), e.ovf);
            check_eq("udf", 32'(udf), e.udf);
        end
        $display("cyc=%0d rst_n=%0b wr=%0b rd=%0b -> wp=%0d rp=%0d usedw=%0d f=%0b e=%0b af=%0b ae=%0b ovf=%0b udf=%0b",
                 cyc, rst_n, w, r, wr_pntr, rd_pntr, usedw, full, empty,
                 almost_full, almost_empty, ovf, udf);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Fill: usedw 1..8, write pointer wraps 7 -> 0.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b1);
        // Drain: read pointer 0..7, usedw 7..0.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1);
        // Both requests while empty: write only, udf sets.
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        // usedw=4 with both requests for 20 cycles.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1);
        // Write while full, no read: rejected, ovf sets and sticks.
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        // Both requests while full: read only.
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Reset at usedw=5 with a write pending.
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
